hamming_block_checker: RTL and testbench
========================================

Name: hamming_block_checker

Overview:
- Pipelined consumer of packed Hamming blocks. Data bits and parity bits are interleaved, with parity bit i at block index 2**i-1.
- Sits downstream of the block packager, after storage or transport. Computes the syndrome, corrects single-bit errors, extracts the data word and reports error status.
- Valid/ready on both sides. Saturating counters for corrected and uncorrectable events.

Parameters:
- DATA_WIDTH, 8, data word width; must be ≥ 1.
- COUNTER_WIDTH, 16, width of each error-event counter.
- PARITY_WIDTH, localparam, smallest p with 2**p ≥ DATA_WIDTH+p+1 (4 for DATA_WIDTH=8).
- BLOCK_WIDTH, localparam, DATA_WIDTH+PARITY_WIDTH.

Ports:
- clock  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  in_block is valid.
- in_ready  output  1  checker accepts in_block this cycle.
- in_block  input  BLOCK_WIDTH  packed block; bit k is Hamming position k+1.
- out_valid  output  1  output fields are valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  DATA_WIDTH  corrected data, in block order, with parity positions skipped.
- out_syndrome  output  PARITY_WIDTH  raw syndrome of the block.
- out_corrected  output  1  single-bit error corrected; data or parity bit.
- out_uncorrectable  output  1  syndrome > BLOCK_WIDTH; data is not corrected.
- clear_counters  input  1  synchronous clear of both counters.
- corrected_count  output  COUNTER_WIDTH  saturating count of corrected blocks.
- uncorrectable_count  output  COUNTER_WIDTH  saturating count of uncorrectable blocks.

Behaviour:
- Syndrome = XOR over all set block bits of (k+1).
  - 0: no error.
  - 1..BLOCK_WIDTH: flip block bit syndrome-1; out_corrected=1.
  - Above BLOCK_WIDTH: out_uncorrectable=1; data extracted from the uncorrected block.
  - Double errors whose syndrome falls in range are silently miscorrected. This is inherent to the code (no extended parity).
- Two-stage elastic pipeline:
  - S1 registers the block and its syndrome.
  - S2 registers the corrected data and flags.
- Latency: a block accepted in cycle N appears on out_* in cycle N+2 if not stalled.
- Throughput: 1 block/cycle.
- Each stage advances when its valid is 0 or its consumer accepts.
- in_ready = !s1_valid || s2_can_accept; combinational from out_ready, no skid.
- Handshake: a transfer occurs when valid && ready.
  - out_* must hold stable while out_valid && !out_ready.
  - in_block is sampled only on the input handshake.
- Counters:
  - Increment on the output handshake when the corresponding flag is set.
  - Saturate at all-ones; no wrap.
  - If clear_counters is asserted in the same cycle as an increment, clear wins and the event is not counted.
- Reset values (synchronous, highest priority):
  - s1_valid=0, out_valid=0.
  - out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0.
  - Both counters 0.
  - in_ready=1 in the first cycle after reset deasserts.
- Reset during operation: all in-flight blocks are dropped, nothing is emitted, and counters are zeroed.
- Input while full (both stages valid, out_ready=0): in_ready=0 and the block is not accepted.

Test Plan:
- DATA_WIDTH=8 (block 12 bits). Send 0xA27, out_ready=1 → two cycles later: out_data=0xA5, out_syndrome=0, out_corrected=0, out_uncorrectable=0; counters unchanged.
- Send 0xA07 (bit 5 flipped) → out_data=0xA5, out_syndrome=6, out_corrected=1; corrected_count=1 after the handshake.
- Send 0xA26 (parity bit 0 flipped) → out_data=0xA5, out_syndrome=1, out_corrected=1.
- Send 0x226 (bits 0 and 11 flipped) → out_syndrome=13, out_uncorrectable=1, out_data=0x25; uncorrectable_count increments.
- Stream 4 blocks with out_ready=0 for 3 cycles:
  - Expected: in_ready drops after 2 accepted blocks; out_* held stable.
  - After release, all 4 blocks are emitted in order with no loss or duplication.
- Corner cases:
  - Preload corrected_count to all-ones via repeated errors with COUNTER_WIDTH=2 → count stays 3.
  - Assert clear_counters together with an error handshake → count is 0.
  - Assert reset with 2 blocks in flight → out_valid=0 next cycle, nothing emitted.

Source files
------------

// File: rtl/hamming_block_checker.sv
// Hamming block checker: computes the syndrome of each packed block, corrects
// single-bit errors, strips parity positions and counts error events.
module hamming_block_checker #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 16,
  // Smallest p with 2**p >= DATA_WIDTH+p+1 (table covers DATA_WIDTH up to 1013)
  localparam int unsigned PARITY_WIDTH =
    (DATA_WIDTH <= 1)   ? 2 :
    (DATA_WIDTH <= 4)   ? 3 :
    (DATA_WIDTH <= 11)  ? 4 :
    (DATA_WIDTH <= 26)  ? 5 :
    (DATA_WIDTH <= 57)  ? 6 :
    (DATA_WIDTH <= 120) ? 7 :
    (DATA_WIDTH <= 247) ? 8 :
    (DATA_WIDTH <= 502) ? 9 : 10,
  localparam int unsigned BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BLOCK_WIDTH-1:0]   in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [PARITY_WIDTH-1:0]  out_syndrome,
  output logic                     out_corrected,
  output logic                     out_uncorrectable,
  input  logic                     clear_counters,
  output logic [COUNTER_WIDTH-1:0] corrected_count,
  output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

  // XOR of the 1-based positions of all set bits
  function automatic logic [PARITY_WIDTH-1:0] calc_syndrome(input logic [BLOCK_WIDTH-1:0] blk);
    logic [PARITY_WIDTH-1:0] syn;
    syn = '0;
    for (int unsigned k = 0; k < BLOCK_WIDTH; k++) begin
      if (blk[k]) syn = syn ^ PARITY_WIDTH'(k + 1);
    end
    return syn;
  endfunction

  // Collect data bits in block order, skipping power-of-two positions
  function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [BLOCK_WIDTH-1:0] blk);
    logic [DATA_WIDTH-1:0] data;
    int unsigned           j;
    data = '0;
    j    = 0;
    for (int unsigned k = 0; k < BLOCK_WIDTH; k++) begin
      if ((((k + 1) & k) != 0) && (j < DATA_WIDTH)) begin
        data[j] = blk[k];
        j       = j + 1;
      end
    end
    return data;
  endfunction

  logic                     s1_valid_q, s1_valid_d;
  logic [BLOCK_WIDTH-1:0]   s1_block_q, s1_block_d;
  logic [PARITY_WIDTH-1:0]  s1_syndrome_q, s1_syndrome_d;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [PARITY_WIDTH-1:0]  out_syndrome_q, out_syndrome_d;
  logic                     out_corrected_q, out_corrected_d;
  logic                     out_uncorrectable_q, out_uncorrectable_d;

  logic [COUNTER_WIDTH-1:0] corrected_count_q, corrected_count_d;
  logic [COUNTER_WIDTH-1:0] uncorrectable_count_q, uncorrectable_count_d;

  logic                     s2_can_accept;
  logic                     out_fire;
  logic [BLOCK_WIDTH-1:0]   fixed_block;

  always_comb begin
    s2_can_accept = !out_valid_q || out_ready;
    in_ready      = !s1_valid_q || s2_can_accept;
    out_fire      = out_valid_q && out_ready;

    s1_valid_d    = s1_valid_q;
    s1_block_d    = s1_block_q;
    s1_syndrome_d = s1_syndrome_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_block_d    = in_block;
        s1_syndrome_d = calc_syndrome(in_block);
      end
    end

    // Only an in-range syndrome matches a position, so out-of-range leaves data untouched
    fixed_block = s1_block_q;
    for (int unsigned k = 0; k < BLOCK_WIDTH; k++) begin
      if (s1_syndrome_q == PARITY_WIDTH'(k + 1)) fixed_block[k] = ~s1_block_q[k];
    end

    out_valid_d         = out_valid_q;
    out_data_d          = out_data_q;
    out_syndrome_d      = out_syndrome_q;
    out_corrected_d     = out_corrected_q;
    out_uncorrectable_d = out_uncorrectable_q;
    if (s2_can_accept) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d          = extract_data(fixed_block);
        out_syndrome_d      = s1_syndrome_q;
        out_corrected_d     = (s1_syndrome_q != '0) && (32'(s1_syndrome_q) <= BLOCK_WIDTH);
        out_uncorrectable_d = 32'(s1_syndrome_q) > BLOCK_WIDTH;
      end
    end

    // Clear takes priority over a same-cycle event
    corrected_count_d     = corrected_count_q;
    uncorrectable_count_d = uncorrectable_count_q;
    if (clear_counters) begin
      corrected_count_d     = '0;
      uncorrectable_count_d = '0;
    end else if (out_fire) begin
      if (out_corrected_q && (corrected_count_q != '1))
        corrected_count_d = corrected_count_q + COUNTER_WIDTH'(1);
      if (out_uncorrectable_q && (uncorrectable_count_q != '1))
        uncorrectable_count_d = uncorrectable_count_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q            <= 1'b0;
      s1_block_q            <= '0;
      s1_syndrome_q         <= '0;
      out_valid_q           <= 1'b0;
      out_data_q            <= '0;
      out_syndrome_q        <= '0;
      out_corrected_q       <= 1'b0;
      out_uncorrectable_q   <= 1'b0;
      corrected_count_q     <= '0;
      uncorrectable_count_q <= '0;
    end else begin
      s1_valid_q            <= s1_valid_d;
      s1_block_q            <= s1_block_d;
      s1_syndrome_q         <= s1_syndrome_d;
      out_valid_q           <= out_valid_d;
      out_data_q            <= out_data_d;
      out_syndrome_q        <= out_syndrome_d;
      out_corrected_q       <= out_corrected_d;
      out_uncorrectable_q   <= out_uncorrectable_d;
      corrected_count_q     <= corrected_count_d;
      uncorrectable_count_q <= uncorrectable_count_d;
    end
  end

  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign out_syndrome        = out_syndrome_q;
  assign out_corrected       = out_corrected_q;
  assign out_uncorrectable   = out_uncorrectable_q;
  assign corrected_count     = corrected_count_q;
  assign uncorrectable_count = uncorrectable_count_q;

endmodule

// File: tb/tb_hamming_block_checker.sv
// Directed bench for hamming_block_checker (DATA_WIDTH=8, 2-bit counters).
module tb_hamming_block_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_block;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_syndrome;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic        clear_counters;
  logic [1:0]  corrected_count;
  logic [1:0]  uncorrectable_count;

  hamming_block_checker #(
    .DATA_WIDTH    (8),
    .COUNTER_WIDTH (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_block            (in_block),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_syndrome        (out_syndrome),
    .out_corrected       (out_corrected),
    .out_uncorrectable   (out_uncorrectable),
    .clear_counters      (clear_counters),
    .corrected_count     (corrected_count),
    .uncorrectable_count (uncorrectable_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [3:0] s, input logic c, input logic u);
    exp_t e;
    e.data = d;
    e.syn  = s;
    e.corr = c;
    e.unc  = u;
    return e;
  endfunction

  // Output monitor: in-order scoreboard plus hold-stable check under backpressure
  logic       prev_stall = 1'b0;
  logic [7:0] hold_data;
  logic [3:0] hold_syn;
  logic       hold_corr, hold_unc;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_syn", 32'(out_syndrome), 32'(hold_syn));
        check("hold_flags", 32'({out_corrected, out_uncorrectable}), 32'({hold_corr, hold_unc}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
          check("out_corrected", 32'(out_corrected), 32'(e.corr));
          check("out_uncorrectable", 32'(out_uncorrectable), 32'(e.unc));
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_data  = out_data;
      hold_syn   = out_syndrome;
      hold_corr  = out_corrected;
      hold_unc   = out_uncorrectable;
    end
  end

  task automatic send(input logic [11:0] b, input exp_t e);
    logic ok;
    ok = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_block = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        q.push_back(e);
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) check("accept_timeout", 32'(in_ready), 32'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clock);
    check("drain_empty", 32'(q.size()), 32'(0));
    @(posedge clock); #1;
  endtask

  logic [11:0] blk[4];
  exp_t        ex[4];
  int          idx;
  logic        saw;

  initial begin
    blk[0] = 12'hA27; ex[0] = mk(8'hA5, 4'd0, 1'b0, 1'b0);
    blk[1] = 12'hA07; ex[1] = mk(8'hA5, 4'd6, 1'b1, 1'b0);
    blk[2] = 12'hA26; ex[2] = mk(8'hA5, 4'd1, 1'b1, 1'b0);
    blk[3] = 12'h226; ex[3] = mk(8'h25, 4'd13, 1'b0, 1'b1);

    reset = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b1; clear_counters = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_syndrome", 32'(out_syndrome), 32'(0));
    check("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'(0));
    check("rst_counts", 32'({corrected_count, uncorrectable_count}), 32'(0));

    // Clean block with explicit two-cycle latency
    @(posedge clock); #1;
    in_valid = 1'b1; in_block = blk[0];
    q.push_back(ex[0]);
    @(negedge clock);
    check("lat_in_ready", 32'(in_ready), 32'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("lat_n1_valid", 32'(out_valid), 32'(0));
    @(negedge clock);
    check("lat_n2_valid", 32'(out_valid), 32'(1));
    drain();
    check("clean_corr_cnt", 32'(corrected_count), 32'(0));
    check("clean_unc_cnt", 32'(uncorrectable_count), 32'(0));

    send(blk[1], ex[1]); drain();
    check("d5_corr_cnt", 32'(corrected_count), 32'(1));
    send(blk[2], ex[2]); drain();
    check("p0_corr_cnt", 32'(corrected_count), 32'(2));
    send(blk[3], ex[3]); drain();
    check("dbl_unc_cnt", 32'(uncorrectable_count), 32'(1));
    check("dbl_corr_cnt", 32'(corrected_count), 32'(2));

    // Stream of 4 with out_ready low for the first 3 cycles
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      @(posedge clock); #1;
      out_ready = (cyc >= 3);
      in_valid  = 1'b1;
      in_block  = blk[idx];
      @(negedge clock);
      if (cyc == 2) begin
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_accepted", 32'(idx), 32'(2));
      end
      if (in_ready) begin
        q.push_back(ex[idx]);
        idx++;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 32'(idx), 32'(4));
    drain();
    check("sat_corr_cnt", 32'(corrected_count), 32'(3));
    check("stream_unc_cnt", 32'(uncorrectable_count), 32'(2));
    send(blk[1], ex[1]); drain();
    check("sat_hold_cnt", 32'(corrected_count), 32'(3));

    // Clear coincides with a corrected-block handshake
    out_ready = 1'b0;
    send(blk[1], ex[1]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    check("clr_wait_valid", 32'(out_valid), 32'(1));
    @(posedge clock); #1;
    out_ready = 1'b1; clear_counters = 1'b1;
    @(posedge clock); #1;
    clear_counters = 1'b0;
    check("clr_corr_cnt", 32'(corrected_count), 32'(0));
    check("clr_unc_cnt", 32'(uncorrectable_count), 32'(0));
    check("clr_q_empty", 32'(q.size()), 32'(0));

    send(blk[3], ex[3]); drain();
    check("pre_rst_unc_cnt", 32'(uncorrectable_count), 32'(1));

    // Reset with two blocks in flight
    out_ready = 1'b0;
    send(blk[0], ex[0]);
    send(blk[1], ex[1]);
    reset = 1'b1;
    q.delete();
    @(posedge clock); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_unc_cnt", 32'(uncorrectable_count), 32'(0));
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) saw = 1'b1;
      @(negedge clock);
    end
    check("post_rst_quiet", 32'(saw), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
